// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART receiver: default frame
//                timing and width, and the receiver FSM state encoding.
//                The PARITY state exists only when UART_RX_PARITY_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // 25 MHz system clock / 9600 baud
    localparam int c_CLKS_PER_BIT = 2604;
    localparam int c_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Two-flop synchronizer for the asynchronous serial line plus
//                a falling-edge detector on the synchronized value.
//  Ports       : clk       - system clock (rising edge)
//                rstn      - synchronous active-low reset; all flops go to 1
//                i_rx_in   - raw asynchronous serial line (idle high)
//                o_line    - synchronized line level
//                o_fall    - one-cycle pulse: synchronized line went 1 -> 0
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic i_rx_in,
    output logic o_line,
    output logic o_fall
);

    logic r_meta;
    logic r_line;
    logic r_line_d;

    // Resetting to 1 (idle level) keeps a reset release from looking like
    // a start edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_meta   <= 1'b1;
            r_line   <= 1'b1;
            r_line_d <= 1'b1;
        end else begin
            r_meta   <= i_rx_in;
            r_line   <= r_meta;
            r_line_d <= r_line;
        end
    end

    assign o_line = r_line;
    assign o_fall = r_line_d & ~r_line;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver, LSB first, 1 start bit, DATA_BITS data bits,
//                optional even parity bit, 1 stop bit. Bits are sampled at
//                their centre; the FSM returns to IDLE mid-stop-bit so a
//                back-to-back frame is not lost.
//  Config      : UART_RX_PARITY_EN - when defined, a PARITY state follows
//                DATA (even parity); when undefined o_parity_err is tied 0.
//  Ports       : clk          - system clock (rising edge)
//                rstn         - synchronous active-low reset
//                i_rx_in      - asynchronous serial line, idle high
//                o_rx_data    - last correctly received word
//                o_rx_valid   - strobe: o_rx_data updated this cycle
//                o_frame_err  - strobe: stop bit sampled low
//                o_parity_err - strobe: parity mismatch
//                o_busy       - high whenever the FSM is not IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT,
    parameter int DATA_BITS    = c_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_rx_in,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_busy
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_BITS - 1);

    logic w_line;
    logic w_fall;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rstn    (rstn),
        .i_rx_in (i_rx_in),
        .o_line  (w_line),
        .o_fall  (w_fall)
    );

    rx_state_t              r_state,     w_state_nxt;
    logic [c_CNT_W-1:0]     r_cnt,       w_cnt_nxt;
    logic [c_BIT_W-1:0]     r_bit_cnt,   w_bit_cnt_nxt;
    logic [DATA_BITS-1:0]   r_shift,     w_shift_nxt;
    logic [DATA_BITS-1:0]   r_rx_data,   w_rx_data_nxt;
    logic                   r_rx_valid,  w_rx_valid_nxt;
    logic                   r_frame_err, w_frame_err_nxt;
`ifdef UART_RX_PARITY_EN
    logic                   r_parity_err, w_parity_err_nxt;
    // Remembers a parity failure so the stop bit can suppress o_rx_valid.
    logic                   r_par_bad,    w_par_bad_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
            r_par_bad    <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_rx_data    <= w_rx_data_nxt;
            r_rx_valid   <= w_rx_valid_nxt;
            r_frame_err  <= w_frame_err_nxt;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= w_parity_err_nxt;
            r_par_bad    <= w_par_bad_nxt;
`endif
        end
    end

    // The count defaults to 0, so it is cleared on every state change and at
    // every sample point; it only increments while waiting for a sample.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = '0;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_shift_nxt      = r_shift;
        w_rx_data_nxt    = r_rx_data;
        w_rx_valid_nxt   = 1'b0;
        w_frame_err_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_parity_err_nxt = 1'b0;
        w_par_bad_nxt    = r_par_bad;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nxt   = S_START;
                    w_bit_cnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
                    w_par_bad_nxt = 1'b0;
`endif
                end
            end
            S_START: begin
                // Mid-start-bit check rejects glitches shorter than half a bit.
                if (r_cnt == c_CNT_HALF) begin
                    w_state_nxt = w_line ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_shift_nxt   = {w_line, r_shift[DATA_BITS-1:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == c_BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == c_CNT_LAST) begin
                    // Even parity: data bits plus parity bit XOR to 0.
                    if ((^r_shift) != w_line) begin
                        w_parity_err_nxt = 1'b1;
                        w_par_bad_nxt    = 1'b1;
                    end
                    w_state_nxt = S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == c_CNT_LAST) begin
                    if (w_line) begin
`ifdef UART_RX_PARITY_EN
                        if (!r_par_bad) begin
                            w_rx_valid_nxt = 1'b1;
                            w_rx_data_nxt  = r_shift;
                        end
`else
                        w_rx_valid_nxt = 1'b1;
                        w_rx_data_nxt  = r_shift;
`endif
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = S_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_BREAK: begin
                if (w_line) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_rx_data   = r_rx_data;
    assign o_rx_valid  = r_rx_valid;
    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. A fast instance (16 clk/bit)
//                runs a vector table and corner sequences against a
//                scoreboard of expected strobes; a default-parameter instance
//                (2604 clk/bit) runs the full-rate good frame and false start.
//                Honours UART_RX_PARITY_EN to insert parity bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB   = 16;
    localparam int CPB_S = c_CLKS_PER_BIT;

    localparam logic [1:0] K_VALID = 2'd0;
    localparam logic [1:0] K_FERR  = 2'd1;
    localparam logic [1:0] K_PERR  = 2'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic       r_line_f;
    logic       r_line_s;
    logic [7:0] w_data_f, w_data_s;
    logic       w_valid_f, w_ferr_f, w_perr_f, w_busy_f;
    logic       w_valid_s, w_ferr_s, w_perr_s, w_busy_s;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_rx_in      (r_line_f),
        .o_rx_data    (w_data_f),
        .o_rx_valid   (w_valid_f),
        .o_frame_err  (w_ferr_f),
        .o_parity_err (w_perr_f),
        .o_busy       (w_busy_f)
    );

    uart_rx u_dut_slow (
        .clk          (clk),
        .rstn         (rstn),
        .i_rx_in      (r_line_s),
        .o_rx_data    (w_data_s),
        .o_rx_valid   (w_valid_s),
        .o_frame_err  (w_ferr_s),
        .o_parity_err (w_perr_s),
        .o_busy       (w_busy_s)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard for the fast instance ----------------
    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       sb_e;
    logic       prev_strobe = 1'b0;
    logic [1:0] mon_kind;

    task automatic expect_ev(input logic [1:0] k, input logic [7:0] d);
        exp_t e;
        e.kind = k;
        e.data = d;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (w_valid_f | w_ferr_f | w_perr_f) begin
            check("strobe_onehot", 32'(w_valid_f) + 32'(w_ferr_f) + 32'(w_perr_f), 1);
            check("strobe_not_consecutive", prev_strobe, 1'b0);
            mon_kind = w_valid_f ? K_VALID : (w_ferr_f ? K_FERR : K_PERR);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_strobe: got kind %0d data 0x%0h expected none", mon_kind, w_data_f);
            end else begin
                sb_e = sb_q.pop_front();
                check("strobe_kind", mon_kind, sb_e.kind);
                if (sb_e.kind == K_VALID) check("rx_data_at_valid", w_data_f, sb_e.data);
            end
        end
        prev_strobe <= w_valid_f | w_ferr_f | w_perr_f;
    end

    // ---------------- strobe counters for the slow instance ----------------
    int n_valid_s = 0;
    int n_ferr_s  = 0;
    int n_perr_s  = 0;
    always @(negedge clk) begin
        if (w_valid_s) n_valid_s++;
        if (w_ferr_s)  n_ferr_s++;
        if (w_perr_s)  n_perr_s++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_bit(input bit slow, input logic v, input int n);
        if (slow) r_line_s = v;
        else      r_line_f = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input bit slow, input logic [7:0] d, input logic par_bad,
                              input logic stop, input bit glitch);
        int cpb;
        cpb = slow ? CPB_S : CPB;
        drive_bit(slow, 1'b0, cpb);
        for (int i = 0; i < 8; i++) begin
            if (glitch) begin
                // Short inverted pulse at the bit boundary, well away from the centre.
                drive_bit(slow, ~d[i], 2);
                drive_bit(slow, d[i], cpb - 2);
            end else begin
                drive_bit(slow, d[i], cpb);
            end
        end
`ifdef UART_RX_PARITY_EN
        drive_bit(slow, (^d) ^ par_bad, cpb);
`else
        if (par_bad) $display("note: parity disabled, par_bad ignored");
`endif
        drive_bit(slow, stop, cpb);
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 4 * CPB && sb_q.size() != 0; t++) @(negedge clk);
        #1;
        check(name, sb_q.size(), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] data;
        logic       par_bad;
        logic       stop;
        bit         glitch;
        bit         chain;      // next frame follows with no idle gap
        bit         exp_valid;
        bit         exp_ferr;
        bit         exp_perr;
    } vec_t;

    vec_t       vt[$];
    logic [7:0] last_good;
    logic [7:0] v55;

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            data   pbad  stop  glch chain valid ferr perr
        vt.push_back('{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        vt.push_back('{8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        vt.push_back('{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vt.push_back('{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        vt.push_back('{8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        vt.push_back('{8'h96, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
`ifdef UART_RX_PARITY_EN
        vt.push_back('{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        vt.push_back('{8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        vt.push_back('{8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
`endif

        // ---------------- reset state ----------------
        rstn     = 1'b0;
        r_line_f = 1'b1;
        r_line_s = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_rx_data", w_data_f, 8'h00);
        check("reset_strobes", {w_valid_f, w_ferr_f, w_perr_f}, 3'b000);
        check("reset_busy", w_busy_f, 1'b0);
        check("reset_busy_slow", w_busy_s, 1'b0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // ---------------- full-rate good frame 0xA5 ----------------
        send_frame(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
        r_line_s = 1'b1;
        repeat (10) @(negedge clk);
        check("slow_a5_valid_count", n_valid_s, 1);
        check("slow_a5_ferr_count", n_ferr_s, 0);
        check("slow_a5_data", w_data_s, 8'hA5);
        check("slow_a5_busy_after", w_busy_s, 1'b0);

        // ---------------- full-rate false start ----------------
        r_line_s = 1'b0;
        repeat (500) @(negedge clk);
        check("slow_false_start_busy_in_start", w_busy_s, 1'b1);
        repeat (500) @(negedge clk);
        r_line_s = 1'b1;
        repeat (2000) @(negedge clk);
        check("slow_false_start_busy", w_busy_s, 1'b0);
        check("slow_false_start_strobes", n_valid_s + n_ferr_s + n_perr_s, 1);
        check("slow_false_start_data", w_data_s, 8'hA5);

        // ---------------- table-driven frames on the fast instance ----------------
        last_good = 8'h00;
        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].exp_perr)  expect_ev(K_PERR, vt[i].data);
            if (vt[i].exp_ferr)  expect_ev(K_FERR, vt[i].data);
            if (vt[i].exp_valid) expect_ev(K_VALID, vt[i].data);
            send_frame(1'b0, vt[i].data, vt[i].par_bad, vt[i].stop, vt[i].glitch);
            if (vt[i].exp_valid) last_good = vt[i].data;
            if (!vt[i].chain) begin
                r_line_f = 1'b1;
                drain("vec_drain");
                repeat (2 * CPB) @(negedge clk);
                check("vec_rx_data", w_data_f, last_good);
                check("vec_busy_idle", w_busy_f, 1'b0);
            end
        end

        // ---------------- stop low, line held low (break) ----------------
        expect_ev(K_FERR, 8'h3C);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (5000) @(negedge clk);
        check("break_busy_while_low", w_busy_f, 1'b1);
        check("break_ferr_seen", sb_q.size(), 0);
        r_line_f = 1'b1;
        repeat (6) @(negedge clk);
        check("break_busy_after_high", w_busy_f, 1'b0);
        check("break_rx_data_unchanged", w_data_f, last_good);

        // ---------------- reset during bit 4 of 0x55 ----------------
        v55 = 8'h55;
        drive_bit(1'b0, 1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, v55[i], CPB);
        drive_bit(1'b0, v55[4], CPB / 2);
        check("midframe_busy_before_reset", w_busy_f, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("midframe_reset_busy", w_busy_f, 1'b0);
        check("midframe_reset_data", w_data_f, 8'h00);
        r_line_f = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        check("midframe_no_strobe", sb_q.size(), 0);
        check("midframe_data_after", w_data_f, 8'h00);

        expect_ev(K_VALID, 8'h81);
        send_frame(1'b0, 8'h81, 1'b0, 1'b1, 1'b0);
        r_line_f = 1'b1;
        drain("post_reset_drain");
        check("post_reset_data", w_data_f, 8'h81);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
